// File: rtl/ram_responder_pkg.sv
// Shared types and helpers for the configurable-latency main-memory responder.
// Default geometry lives here so the top and the bench agree on it.
package ram_responder_pkg;

  localparam int ADDR_WIDTH_D = 9;
  localparam int DATA_WIDTH_D = 6;
  localparam int WORDS_D      = 8;
  localparam int LATENCY_D    = 3;

  localparam int OFFS_W = $clog2(WORDS_D);
  localparam int CNT_W  = $clog2(LATENCY_D + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BEAT  = 2'd2,
    WRITE = 2'd3
  } state_t;

  // Clears the word-in-line offset bits, leaving the address of word 0 of the line.
  function automatic logic [31:0] line_base(input logic [31:0] a, input int offs_w);
    return a & ~((32'd1 << offs_w) - 32'd1);
  endfunction

endpackage

// File: rtl/ram_responder_ram_array.sv
// Word storage: synchronous write, registered read that returns zero when not enabled.
// Reset reloads every word with its own index so benches see a known pattern.
module ram_array #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= DATA_WIDTH'(i);
      end
    end else if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= i_re ? r_mem[i_addr] : '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_responder.sv
// Configurable-latency memory on the cache RAM port: single reads, single writes
// and critical-word-first line fills over a ready/valid/done handshake.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_D,
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int WORDS      = WORDS_D,
  parameter int LATENCY    = LATENCY_D
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_WIDTH-1:0]      addr,
  input  logic                       read,
  input  logic                       burst,
  input  logic                       write,
  input  logic [DATA_WIDTH-1:0]      write_data,
  output logic                       ready,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       data_valid,
  output logic [$clog2(WORDS)-1:0]   beat,
  output logic                       done
);

  localparam int P_OFFS_W = $clog2(WORDS);
  localparam int P_CNT_W  = $clog2(LATENCY + 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [P_CNT_W-1:0]    r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_is_write;
  logic                  r_is_burst;
  logic [P_OFFS_W-1:0]   r_offs;
  logic [P_OFFS_W-1:0]   r_nbeat;
  logic                  r_valid;
  logic                  r_done;
  logic [P_OFFS_W-1:0]   r_beat;

  logic                  w_accept;
  logic                  w_cnt_zero;
  logic                  w_issue;
  logic                  w_issue_last;
  logic                  w_we;
  logic                  w_done_nxt;
  logic [ADDR_WIDTH-1:0] w_base;
  logic [ADDR_WIDTH-1:0] w_raddr;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign ready      = (r_state == IDLE);
  assign w_accept   = ready & (read | write);
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // r_done doubles as "the beat on the bus now is the last one".
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = WAIT;
      WAIT:    if (w_cnt_zero) w_state_nxt = r_is_write ? WRITE : BEAT;
      BEAT:    if (r_done) w_state_nxt = IDLE;
      WRITE:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Reads are issued one cycle ahead so the registered RAM output lines up with the beat.
  always_comb begin
    w_issue      = 1'b0;
    w_issue_last = 1'b0;
    w_done_nxt   = 1'b0;
    w_we         = 1'b0;
    case (r_state)
      WAIT: begin
        if (w_cnt_zero) begin
          if (r_is_write) begin
            w_done_nxt = 1'b1;
          end else begin
            w_issue      = 1'b1;
            w_issue_last = ~r_is_burst;
          end
        end
      end
      BEAT: begin
        if (!r_done) begin
          w_issue      = 1'b1;
          w_issue_last = (r_nbeat == P_OFFS_W'(WORDS - 1));
        end
      end
      WRITE:   w_we = 1'b1;
      default: ;
    endcase
    if (w_issue_last) w_done_nxt = 1'b1;
  end

  assign w_base     = ADDR_WIDTH'(line_base(32'(r_addr), P_OFFS_W));
  assign w_raddr    = w_base | ADDR_WIDTH'(r_offs);
  assign w_ram_addr = w_we ? r_addr : w_raddr;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr  <= addr;
      r_wdata <= write_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_is_write <= 1'b0;
      r_is_burst <= 1'b0;
      r_offs     <= '0;
      r_nbeat    <= '0;
    end else if (w_accept) begin
      r_cnt      <= P_CNT_W'(LATENCY - 1);
      r_is_write <= write;
      r_is_burst <= read & burst & ~write;
      r_offs     <= addr[P_OFFS_W-1:0];
      r_nbeat    <= '0;
    end else begin
      if (r_state == WAIT && !w_cnt_zero) r_cnt <= r_cnt - 1'b1;
      if (w_issue) begin
        r_offs  <= r_offs + 1'b1;
        r_nbeat <= r_nbeat + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_beat  <= '0;
    end else begin
      r_valid <= w_issue;
      r_done  <= w_done_nxt;
      r_beat  <= w_issue ? r_offs : '0;
    end
  end

  ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_re    (w_issue),
    .i_addr  (w_ram_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  assign data_out   = w_rdata;
  assign data_valid = r_valid;
  assign beat       = r_beat;
  assign done       = r_done;

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: directed scenarios plus randomized traffic
// checked against a word-array model of the memory.
module tb_ram_responder;

  localparam int AW    = 9;
  localparam int DW    = 6;
  localparam int WORDS = 8;
  localparam int LAT   = 3;
  localparam int OW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr;
  logic          read;
  logic          burst;
  logic          write;
  logic [DW-1:0] write_data;
  logic          ready;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic [OW-1:0] beat;
  logic          done;

  ram_responder #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .WORDS      (WORDS),
    .LATENCY    (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .read       (read),
    .burst      (burst),
    .write      (write),
    .write_data (write_data),
    .ready      (ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .beat       (beat),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            is_wr;
    logic [DW-1:0] data;
    logic [OW-1:0] bt;
    bit            dn;
    int            at;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] mem_m [0:(1<<AW)-1];
  int            n_vec = 0;
  int            n_err = 0;
  bit            mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < (1 << AW); i++) mem_m[i] = DW'(i);
  endtask

  task automatic clear_inputs();
    addr = '0; read = 1'b0; burst = 1'b0; write = 1'b0; write_data = '0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("ready_timeout", {31'd0, ready}, 32'd1);
  endtask

  // Scoreboard monitor: every response beat pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && rst === 1'b1) begin
      if (data_valid === 1'b1 || done === 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_response", {30'd0, data_valid, done}, 32'd0);
        end else begin
          e = q.pop_front();
          check("resp_cycle", cyc, e.at);
          if (e.is_wr) begin
            check("wr_no_valid", {31'd0, data_valid}, 32'd0);
            check("wr_done", {31'd0, done}, 32'd1);
          end else begin
            check("rd_valid", {31'd0, data_valid}, 32'd1);
            check("rd_data", {26'd0, data_out}, {26'd0, e.data});
            check("rd_beat", {29'd0, beat}, {29'd0, e.bt});
            check("rd_done", {31'd0, done}, {31'd0, e.dn});
          end
        end
      end else begin
        check("idle_outputs_zero", {23'd0, data_out, beat}, 32'd0);
      end
    end
  end

  task automatic issue(input bit rd, input bit wr, input bit bs,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input bit poke);
    exp_t e;
    int   k, per, n, base, o;
    wait_ready();
    k = cyc;
    per = 0;
    addr = a; read = rd; write = wr; burst = bs; write_data = d;
    if (wr) begin
      e.is_wr = 1'b1; e.data = '0; e.bt = '0; e.dn = 1'b1; e.at = k + LAT + 1;
      q.push_back(e);
      mem_m[a] = d;
      per = LAT + 2;
    end else if (rd && bs) begin
      base = (int'(a) / WORDS) * WORDS;
      for (int i = 0; i < WORDS; i++) begin
        o = (int'(a) % WORDS + i) % WORDS;
        e.is_wr = 1'b0; e.data = mem_m[base + o]; e.bt = OW'(o);
        e.dn = (i == WORDS - 1); e.at = k + LAT + 1 + i;
        q.push_back(e);
      end
      per = LAT + WORDS + 1;
    end else if (rd) begin
      e.is_wr = 1'b0; e.data = mem_m[a]; e.bt = OW'(int'(a) % WORDS); e.dn = 1'b1;
      e.at = k + LAT + 1;
      q.push_back(e);
      per = LAT + 2;
    end
    @(negedge clk);
    clear_inputs();
    if (!(rd || wr)) begin
      check("ignored_keeps_ready", {31'd0, ready}, 32'd1);
    end else begin
      check("ready_drop", {31'd0, ready}, 32'd0);
      if (poke) begin
        @(negedge clk);
        read = 1'b1; write = 1'b1; burst = 1'b1;
        addr = AW'($urandom); write_data = DW'($urandom);
        @(negedge clk);
        clear_inputs();
      end
      n = 0;
      while (ready !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("ready_return_cycle", cyc, k + per);
    end
  endtask

  initial begin
    int k, r;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    rst = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_data_beat", {23'd0, data_out, beat}, 32'd0);
    rst = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    issue(1'b1, 1'b0, 1'b0, 9'h015, 6'h00, 1'b0);
    issue(1'b0, 1'b1, 1'b0, 9'h020, 6'h3F, 1'b0);
    issue(1'b1, 1'b0, 1'b0, 9'h020, 6'h00, 1'b0);
    issue(1'b1, 1'b0, 1'b1, 9'h02D, 6'h00, 1'b0);
    issue(1'b1, 1'b1, 1'b0, 9'h001, 6'h00, 1'b0);
    issue(1'b1, 1'b0, 1'b0, 9'h001, 6'h00, 1'b0);
    issue(1'b0, 1'b0, 1'b1, 9'h002, 6'h07, 1'b0);
    issue(1'b1, 1'b0, 1'b1, 9'h1FF, 6'h00, 1'b1);
    issue(1'b1, 1'b0, 1'b1, 9'h000, 6'h00, 1'b0);

    // Reset in the middle of a pending write: write dropped, no done.
    wait_ready();
    k = cyc;
    addr = 9'h030; write = 1'b1; write_data = 6'h11;
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_ready", {31'd0, ready}, 32'd1);
    check("midrst_valid_done", {30'd0, data_valid, done}, 32'd0);
    check("midrst_data_beat", {23'd0, data_out, beat}, 32'd0);
    q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    issue(1'b1, 1'b0, 1'b0, 9'h030, 6'h00, 1'b0);

    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 9);
      a = AW'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) a = AW'($urandom);
      d = DW'($urandom);
      case (r)
        0, 1, 2: issue(1'b1, 1'b0, 1'b0, a, d, $urandom_range(0, 7) == 0);
        3, 4:    issue(1'b1, 1'b0, 1'b1, a, d, $urandom_range(0, 3) == 0);
        5, 6, 7: issue(1'b0, 1'b1, 1'b0, a, d, $urandom_range(0, 7) == 0);
        8:       issue(1'b1, 1'b1, 1'($urandom_range(0, 1)), a, d, 1'b0);
        default: issue(1'b0, 1'b0, 1'b1, a, d, 1'b0);
      endcase
    end

    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
